// File: rtl/monedero.sv
// Coin-payment controller for the drink machine: accumulates coin credit against the
// selected price, signals payment to maquina and pays back change one unit per cycle.
module monedero #(
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] precio,
  input  logic       SELECCION_valida,
  input  logic       moneda_valida,
  input  logic [1:0] moneda_valor,
  input  logic       cancelar,
  input  logic       listo,
  output logic       PAGO_RECIBIDO,
  output logic [4:0] credito,
  output logic       esperando_pago,
  output logic       vuelto_pulso,
  output logic       moneda_rechazada
);

  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS + 1) : 1;

  typedef enum logic [1:0] {IDLE, COBRO, PAGADO, VUELTO} state_t;

  state_t        state, state_next;
  logic [4:0]    credito_next;
  logic [3:0]    precio_reg, precio_reg_next;
  logic [CW-1:0] cuenta, cuenta_next;
  logic          rechazo_next;
  logic          moneda_ok;
  logic          fin_espera;
  logic [4:0]    valor;
  logic [4:0]    suma;

  always_comb begin
    valor = 5'd0;
    case (moneda_valor)
      2'b00:   valor = 5'd1;
      2'b01:   valor = 5'd2;
      2'b10:   valor = 5'd5;
      default: valor = 5'd0;
    endcase
  end

  // Credit never exceeds 14 + 5 = 19 before leaving COBRO, so five bits never wrap.
  assign suma       = credito + valor;
  assign moneda_ok  = moneda_valida && (moneda_valor != 2'b11) && (state == COBRO);
  assign fin_espera = (cuenta == CW'(TIMEOUT_CICLOS - 1));

  always_comb begin
    state_next      = state;
    credito_next    = credito;
    precio_reg_next = precio_reg;
    cuenta_next     = '0;
    rechazo_next    = moneda_valida && !moneda_ok;

    case (state)
      IDLE: begin
        credito_next = 5'd0;
        if (SELECCION_valida && (precio != 4'd0)) begin
          precio_reg_next = precio;
          state_next      = COBRO;
        end
      end

      COBRO: begin
        if (moneda_ok) begin
          credito_next = suma;
        end else begin
          cuenta_next = cuenta + CW'(1);
        end
        // The coin is credited first, so a cancel refunds it and beats reaching the price.
        if (cancelar || (!moneda_ok && fin_espera)) begin
          cuenta_next = '0;
          state_next  = (credito_next == 5'd0) ? IDLE : VUELTO;
        end else if (moneda_ok && (suma >= {1'b0, precio_reg})) begin
          state_next = PAGADO;
        end
      end

      PAGADO: begin
        if (listo) begin
          credito_next = credito - {1'b0, precio_reg};
          state_next   = (credito_next == 5'd0) ? IDLE : VUELTO;
        end
      end

      VUELTO: begin
        if (credito <= 5'd1) begin
          credito_next = 5'd0;
          state_next   = IDLE;
        end else begin
          credito_next = credito - 5'd1;
        end
      end

      default: begin
        credito_next = 5'd0;
        state_next   = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with credito.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      credito          <= 5'd0;
      precio_reg       <= 4'd0;
      cuenta           <= '0;
      PAGO_RECIBIDO    <= 1'b0;
      esperando_pago   <= 1'b0;
      vuelto_pulso     <= 1'b0;
      moneda_rechazada <= 1'b0;
    end else begin
      state            <= state_next;
      credito          <= credito_next;
      precio_reg       <= precio_reg_next;
      cuenta           <= cuenta_next;
      PAGO_RECIBIDO    <= (state_next == PAGADO);
      esperando_pago   <= (state_next == COBRO);
      vuelto_pulso     <= (state_next == VUELTO);
      moneda_rechazada <= rechazo_next;
    end
  end

endmodule
